// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches an aligned cache block from memory word by word on a miss and strobes the cache data/tag arrays
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic              fsm_busy,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array
);
  localparam int WB = $clog2(DATA_W / 8);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int BO = OFF_W + WB;
  localparam int CNT_W = OFF_W + 1;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state;
  logic [ADDR_W-BO-1:0] base_hi;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] recv_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      base_hi <= '0;
      issue_cnt <= '0;
      recv_cnt <= '0;
    end else if (state == IDLE) begin
      if (miss_detected) begin
        state <= FILL;
        base_hi <= miss_address[ADDR_W-1:BO];
        issue_cnt <= '0;
        recv_cnt <= '0;
      end
    end else begin
      if (mem_read_en) issue_cnt <= issue_cnt + 1'b1;
      if (memory_data_valid) begin
        recv_cnt <= recv_cnt + 1'b1;
        if (write_tag_array) state <= IDLE;
      end
    end
  end
  // only the word-offset bits move; the block part never carries
  always_comb begin
    fsm_busy = state == FILL;
    mem_read_en = fsm_busy && issue_cnt < CNT_W'(BLOCK_WORDS);
    mem_read_addr = {base_hi, issue_cnt[OFF_W-1:0], {WB{1'b0}}};
    memory_address = {base_hi, recv_cnt[OFF_W-1:0], {WB{1'b0}}};
    write_data_array = fsm_busy && memory_data_valid;
    write_tag_array = write_data_array && recv_cnt == CNT_W'(BLOCK_WORDS - 1);
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: randomized scoreboard bench with a pipelined memory model and a word-level fill reference model
module tb_cache_fill_fsm;
  localparam int LAT = 4;
  typedef struct {logic [15:0] a; logic t; int c;} exp_t;
  logic clk = 0;
  logic rst = 1;
  logic miss_detected = 0;
  logic [15:0] miss_address = 0;
  logic memory_data_valid = 0;
  logic mem_read_en, fsm_busy, write_data_array, write_tag_array;
  logic [15:0] mem_read_addr, memory_address;
  cache_fill_fsm dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr),
    .fsm_busy(fsm_busy), .memory_address(memory_address), .write_data_array(write_data_array),
    .write_tag_array(write_tag_array)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0, cyc = 0, next_ok = 0;
  exp_t rq_q[$], wr_q[$];
  int mem_q[$];
  logic m_busy = 0, exp_busy = 0, gaps = 0, miss = 0, spur = 0;
  logic [15:0] maddr = 0, m_base = 0;
  int k = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask
  task automatic chk_zero(input string n);
    chk({n, " en"}, 32'(mem_read_en), 0);
    chk({n, " raddr"}, 32'(mem_read_addr), 0);
    chk({n, " busy"}, 32'(fsm_busy), 0);
    chk({n, " maddr"}, 32'(memory_address), 0);
    chk({n, " wdata"}, 32'(write_data_array), 0);
    chk({n, " wtag"}, 32'(write_tag_array), 0);
  endtask
  // one cycle: drive inputs, then advance the reference model (words of the current fill)
  task automatic step(input logic do_rst = 0);
    logic v;
    @(negedge clk);
    cyc++;
    v = spur;
    if (!spur && mem_q.size() > 0 && mem_q[0] <= cyc && cyc >= next_ok) begin
      v = 1;
      void'(mem_q.pop_front());
      next_ok = cyc + 1 + (gaps ? int'($urandom_range(0, 3)) : 0);
    end
    memory_data_valid = v;
    miss_detected = miss;
    miss_address = maddr;
    if (do_rst) begin
      rst = 1;
      m_busy = 0;
      exp_busy = 0;
      rq_q.delete();
      wr_q.delete();
      #1 chk_zero("async_rst");
      return;
    end
    rst = 0;
    exp_busy = m_busy;
    if (m_busy) begin
      if (v) begin
        wr_q.push_back('{m_base + 16'(2 * k), k == 7, cyc});
        k++;
        if (k == 8) m_busy = 0;
      end
    end else if (miss) begin
      m_base = maddr & 16'hFFF0;
      for (int i = 0; i < 8; i++) rq_q.push_back('{m_base + 16'(2 * i), 0, cyc + 1 + i});
      k = 0;
      m_busy = 1;
    end
  endtask
  task automatic run_idle(input int bound);
    int n = 0;
    miss = 0;
    spur = 0;
    while ((m_busy || mem_q.size() > 0) && n < bound) begin
      step();
      n++;
    end
    if (n >= bound) chk("idle_timeout", 1, 0);
    repeat (2) step();
  endtask
  task automatic fill(input logic [15:0] a);
    maddr = a;
    miss = 1;
    step();
    miss = 0;
    run_idle(200);
  endtask
  // monitor: pops expectations whenever the DUT presents a request or a write
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst !== 1'b1) begin
      chk("busy", 32'(fsm_busy), 32'(exp_busy));
      if (mem_read_en) begin
        mem_q.push_back(cyc + LAT);
        if (rq_q.size() == 0) chk("unexpected_req", 1, 0);
        else begin
          e = rq_q.pop_front();
          chk("req_addr", 32'(mem_read_addr), 32'(e.a));
          chk("req_cycle", cyc, e.c);
        end
      end
      if (write_tag_array && !write_data_array) chk("tag_without_data", 1, 0);
      if (write_data_array) begin
        if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = wr_q.pop_front();
          chk("wr_addr", 32'(memory_address), 32'(e.a));
          chk("wr_tag", 32'(write_tag_array), 32'(e.t));
          chk("wr_cycle", cyc, e.c);
        end
      end
    end
  end
  initial begin
    #1 chk_zero("reset");
    fill(16'h1236);
    fill(16'hFFFF);
    maddr = 16'h4000;
    miss = 1;
    repeat (14) step();
    run_idle(200);
    spur = 1;
    repeat (5) step();
    spur = 0;
    repeat (2) step();
    maddr = 16'h2222;
    miss = 1;
    step();
    miss = 0;
    for (int n = 0; n < 50 && !(m_busy && k == 3); n++) step();
    if (!(m_busy && k == 3)) chk("reset_point_timeout", 1, 0);
    step(1);
    step();
    run_idle(200);
    fill(16'h0080);
    gaps = 1;
    for (int f = 0; f < 5; f++) begin
      maddr = 16'($urandom);
      miss = 1;
      step();
      for (int n = 0; n < 120 && (m_busy || mem_q.size() > 0); n++) begin
        miss = ($urandom_range(0, 3) == 0);
        maddr = 16'($urandom);
        step();
      end
      run_idle(200);
    end
    chk("req_queue_empty", rq_q.size(), 0);
    chk("wr_queue_empty", wr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
